hazard_scoreboard_unit: RTL and testbench

- Parametrised successor to the ID-stage hazard detector.
- Replaces fixed EXE/MEM destination compares with a per-register countdown scoreboard, so in-flight writers of any latency (ALU, load, multi-cycle multiply/divide) are tracked.
- Sits in the ID stage and drives the pipeline freeze.
- Includes a saturating stall performance counter.

---
 rtl/hazard_scoreboard_unit.sv | 100 ++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard scoreboard: per-register countdown of in-flight writers drives freeze.
// Optional macro HAZARD_SCOREBOARD_FWD_EN selects forwarding thresholds (TH=1, no WB_EXTRA).
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 4,
  parameter int WB_EXTRA   = 2,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_W-1:0]     src1_id,
  input  logic [REG_ADDR_W-1:0]     src2_id,
  input  logic                      is_immediate,
  input  logic                      issue_valid,
  input  logic                      wb_en_id,
  input  logic [REG_ADDR_W-1:0]     dest_id,
  input  logic [CNT_W-1:0]          issue_lat,
  input  logic                      perf_clr,
  output logic                      freeze,
  output logic [1:0]                hazard_src,
  output logic [(2**REG_ADDR_W)-1:0] busy_vec,
  output logic [PERF_W-1:0]         stall_cnt
);
  localparam int NUM_REGS = 2**REG_ADDR_W;
`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam logic [CNT_W-1:0] TH    = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXTRA = '0;
`else
  localparam logic [CNT_W-1:0] TH    = '0;
  localparam logic [CNT_W-1:0] EXTRA = CNT_W'(WB_EXTRA);
`endif

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] busy_nxt;
  logic [CNT_W-1:0]    lat_c;
  logic [CNT_W-1:0]    load_val;
  logic [CNT_W-1:0]    dec;
  logic                issue;
  logic [PERF_W-1:0]   stall_q;

  always_comb begin
    hazard_src    = 2'b00;
    hazard_src[0] = issue_valid && (src1_id != '0) && (cnt[src1_id] > TH);
    hazard_src[1] = issue_valid && !is_immediate && (src2_id != '0) && (cnt[src2_id] > TH);
  end

  assign freeze = |hazard_src;
  assign issue  = issue_valid && !freeze && wb_en_id && (dest_id != '0);

  always_comb begin
    if (issue_lat == '0)
      lat_c = CNT_W'(1);
    else if (issue_lat > CNT_W'(MAX_LAT))
      lat_c = CNT_W'(MAX_LAT);
    else
      lat_c = issue_lat;
  end

  assign load_val = lat_c + EXTRA;

  // A newer writer never shortens an older, slower one (WAW): take the max.
  always_comb begin
    dec      = '0;
    busy_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = '0;
      if (r != 0) begin
        dec = (cnt[r] != '0) ? cnt[r] - CNT_W'(1) : '0;
        if (issue && (dest_id == REG_ADDR_W'(r)))
          cnt_nxt[r] = (dec > load_val) ? dec : load_val;
        else
          cnt_nxt[r] = dec;
      end
      busy_nxt[r] = (cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      busy_vec <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
      busy_vec <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (perf_clr)
      stall_q <= '0;
    else if (issue_valid && freeze && (stall_q != '1))
      stall_q <= stall_q + PERF_W'(1);
  end

  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit; expectations follow HAZARD_SCOREBOARD_FWD_EN.
module tb_hazard_scoreboard_unit;
`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  src1_id, src2_id, dest_id;
  logic        is_immediate, issue_valid, wb_en_id, perf_clr;
  logic [2:0]  issue_lat;
  logic        freeze;
  logic [1:0]  hazard_src;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut (
    .clk(clk), .rst_n(rst_n), .src1_id(src1_id), .src2_id(src2_id),
    .is_immediate(is_immediate), .issue_valid(issue_valid), .wb_en_id(wb_en_id),
    .dest_id(dest_id), .issue_lat(issue_lat), .perf_clr(perf_clr),
    .freeze(freeze), .hazard_src(hazard_src), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  task automatic idle(input int n);
    issue_valid = 1'b0; wb_en_id = 1'b0; src1_id = '0; src2_id = '0; dest_id = '0;
    is_immediate = 1'b1; issue_lat = 3'd1; perf_clr = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Issue a producer, then hold a dependent consumer until it stops freezing.
  task automatic produce_consume(input logic [4:0] d, input logic [2:0] lat,
                                 input bit use_src2, input bit imm,
                                 output int stalls, output logic [1:0] first_hz);
    @(negedge clk);
    issue_valid = 1'b1; wb_en_id = 1'b1; dest_id = d; issue_lat = lat;
    src1_id = '0; src2_id = '0; is_immediate = 1'b1;
    @(negedge clk);
    wb_en_id = 1'b0; dest_id = '0;
    src1_id = use_src2 ? 5'd0 : d;
    src2_id = use_src2 ? d : 5'd0;
    is_immediate = imm;
    #1;
    first_hz = hazard_src;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      if (!freeze) break;
      stalls++;
      @(negedge clk); #1;
    end
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      src1_id = 5'($urandom); src2_id = 5'($urandom); dest_id = 5'($urandom);
      issue_lat = 3'($urandom); issue_valid = 1'b1; wb_en_id = 1'b1;
      is_immediate = 1'($urandom); perf_clr = 1'b0;
      #1;
      n_checks++;
      if (freeze !== 1'b0 || busy_vec !== '0 || stall_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_state: freeze=%b busy=%h stall=%h, want 0/0/0", freeze, busy_vec, stall_cnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; wb_en_id = 1'b0; src1_id = 5'd5; src2_id = '0; is_immediate = 1'b1;
    #1;
    n_checks++;
    if (freeze !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_src5: freeze=%b want 0", freeze);
    end
    idle(2);
  endtask

  task automatic test_alu_chain();
    int s; logic [1:0] hz;
    produce_consume(5'd3, 3'd1, 1'b0, 1'b1, s, hz);
    n_checks++;
    if (s !== (FWD ? 0 : 3)) begin
      n_fail++;
      $display("FAIL alu_chain_stalls: got %0d want %0d", s, FWD ? 0 : 3);
    end
    n_checks++;
    if (stall_cnt !== (FWD ? 16'd0 : 16'd3)) begin
      n_fail++;
      $display("FAIL alu_chain_stall_cnt: got %0d want %0d", stall_cnt, FWD ? 0 : 3);
    end
    idle(8);
  endtask

  task automatic test_load_use();
    int s; logic [1:0] hz;
    produce_consume(5'd7, 3'd2, 1'b1, 1'b0, s, hz);
    n_checks++;
    if (hz !== 2'b10) begin
      n_fail++;
      $display("FAIL load_use_hazard_src: got %b want 10", hz);
    end
    n_checks++;
    if (s !== (FWD ? 1 : 4)) begin
      n_fail++;
      $display("FAIL load_use_stalls: got %0d want %0d", s, FWD ? 1 : 4);
    end
    idle(8);
    produce_consume(5'd7, 3'd2, 1'b1, 1'b1, s, hz);
    n_checks++;
    if (s !== 0 || hz !== 2'b00) begin
      n_fail++;
      $display("FAIL load_use_immediate: stalls=%0d hz=%b want 0/00", s, hz);
    end
    idle(8);
  endtask

  task automatic test_waw();
    int busy_cycles;
    @(negedge clk);
    issue_valid = 1'b1; wb_en_id = 1'b1; dest_id = 5'd9; issue_lat = 3'd4;
    src1_id = '0; src2_id = '0; is_immediate = 1'b1;
    @(negedge clk);
    issue_lat = 3'd1;
    @(negedge clk);
    issue_valid = 1'b0; wb_en_id = 1'b0; dest_id = '0;
    #1;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (!busy_vec[9]) break;
      busy_cycles++;
      @(negedge clk); #1;
    end
    n_checks++;
    if (busy_cycles !== (FWD ? 3 : 5)) begin
      n_fail++;
      $display("FAIL waw_busy_cycles: got %0d want %0d", busy_cycles, FWD ? 3 : 5);
    end
    idle(4);
  endtask

  task automatic test_reg0();
    @(negedge clk);
    issue_valid = 1'b1; wb_en_id = 1'b1; dest_id = 5'd0; issue_lat = 3'd4;
    @(negedge clk);
    wb_en_id = 1'b0; src1_id = 5'd0; src2_id = 5'd0; is_immediate = 1'b0;
    #1;
    n_checks++;
    if (freeze !== 1'b0 || busy_vec !== '0) begin
      n_fail++;
      $display("FAIL reg0: freeze=%b busy=%h want 0/0", freeze, busy_vec);
    end
    idle(2);
  endtask

  task automatic test_lat_clamp();
    int s; logic [1:0] hz;
    produce_consume(5'd5, 3'd0, 1'b0, 1'b1, s, hz);
    n_checks++;
    if (s !== (FWD ? 0 : 3)) begin
      n_fail++;
      $display("FAIL lat_zero_stalls: got %0d want %0d", s, FWD ? 0 : 3);
    end
    idle(8);
    produce_consume(5'd6, 3'd7, 1'b0, 1'b1, s, hz);
    n_checks++;
    if (s !== (FWD ? 3 : 6) || hz !== 2'b01) begin
      n_fail++;
      $display("FAIL lat_clamp_stalls: got %0d hz=%b want %0d hz=01", s, hz, FWD ? 3 : 6);
    end
    idle(8);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    issue_valid = 1'b1; wb_en_id = 1'b1; dest_id = 5'd4; issue_lat = 3'd4;
    @(negedge clk);
    issue_valid = 1'b0; wb_en_id = 1'b0;
    #1;
    n_checks++;
    if (busy_vec[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_busy_before: got %b want 1", busy_vec[4]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy_vec !== '0 || stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: busy=%h stall=%h want 0/0", busy_vec, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; issue_valid = 1'b1; src1_id = 5'd4; is_immediate = 1'b1;
    #1;
    n_checks++;
    if (freeze !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_release: freeze=%b want 0", freeze);
    end
    idle(2);
  endtask

  task automatic test_perf_sat();
    @(negedge clk);
    force dut.stall_q = 16'hFFFE;
    @(negedge clk);
    release dut.stall_q;
    #1;
    n_checks++;
    if (stall_cnt !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL perf_preload: got %h want fffe", stall_cnt);
    end
    issue_valid = 1'b1; wb_en_id = 1'b1; dest_id = 5'd1; issue_lat = 3'd4;
    @(negedge clk);
    wb_en_id = 1'b0; dest_id = '0; src1_id = 5'd1;
    @(negedge clk); #1;
    n_checks++;
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL perf_increment: got %h want ffff", stall_cnt);
    end
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL perf_saturate: got %h want ffff", stall_cnt);
    end
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0; issue_valid = 1'b0;
    #1;
    n_checks++;
    if (stall_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL perf_clear: got %h want 0000", stall_cnt);
    end
    idle(8);
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 1'b0; wb_en_id = 1'b0; src1_id = '0; src2_id = '0; dest_id = '0;
    is_immediate = 1'b1; issue_lat = 3'd1; perf_clr = 1'b0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_waw();
    test_reg0();
    test_lat_clamp();
    test_mid_reset();
    test_perf_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
